// File: rtl/pc_gen_pkg.sv
// Shared constants and FSM encoding for the IF-stage program-counter generator.
package pc_gen_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam logic [INST_ADDR_W-1:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;

  localparam int unsigned PC_STEP_32 = 4;
  localparam int unsigned PC_STEP_16 = 2;

  typedef enum logic [1:0] {
    PC_IDLE = 2'd0,
    PC_RUN  = 2'd1,
    PC_HOLD = 2'd2
  } pc_state_e;

endpackage : pc_gen_pkg

// File: rtl/pc_gen_align_chk.sv
// Redirect-target alignment check: word alignment, or halfword alignment with compressed support.
module pc_align_chk #(
  parameter int unsigned XLEN  = 32,
  parameter bit          C_EXT = 1'b0
) (
  input  logic [XLEN-1:0] target_i,
  output logic            misalign_c_o
);

  logic unused_hi_c;

  assign misalign_c_o = target_i[0] | (!C_EXT & target_i[1]);
  assign unused_hi_c  = ^target_i[XLEN-1:2];

endmodule : pc_align_chk

// File: rtl/pc_gen.sv
// Fetch-address generator: sequential stepping, buffered branch redirect, trap redirect
// and rejection of misaligned redirect targets.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN         = INST_ADDR_W,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEF),
  parameter int unsigned     STALL_W      = 6,
  parameter bit              C_EXT        = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STALL_W-1:0] stall,
  input  logic               br_valid,
  input  logic [XLEN-1:0]    br_target,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_target,
  input  logic               if_ready,
  input  logic               inst_len16,
  output logic [XLEN-1:0]    pc,
  output logic               ce,
  output logic               misalign_exc,
  output logic [XLEN-1:0]    misalign_addr
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            ce_q, ce_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic            exc_q, exc_d;
  logic [XLEN-1:0] addr_q, addr_d;

  logic            adv_c;
  logic            hold_c;
  logic            br_mis_c;
  logic            trap_mis_c;
  logic [XLEN-1:0] step_c;
  logic            unused_stall_c;

  pc_align_chk #(.XLEN(XLEN), .C_EXT(C_EXT)) u_br_chk (
    .target_i     (br_target),
    .misalign_c_o (br_mis_c)
  );

  pc_align_chk #(.XLEN(XLEN), .C_EXT(C_EXT)) u_trap_chk (
    .target_i     (trap_target),
    .misalign_c_o (trap_mis_c)
  );

  // Only the PC-stage stall bit matters; the rest of the vector is carried for bus uniformity.
  assign unused_stall_c = ^stall;

  assign adv_c  = ce_q & ~stall[0] & if_ready;
  assign hold_c = (state_q == PC_HOLD) && pend_valid_q;
  assign step_c = (C_EXT && inst_len16) ? XLEN'(PC_STEP_16) : XLEN'(PC_STEP_32);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PC_IDLE;
      pc_q          <= RESET_VECTOR;
      ce_q          <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      exc_q         <= 1'b0;
      addr_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ce_q          <= ce_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      exc_q         <= exc_d;
      addr_q        <= addr_d;
    end
  end

  // Redirect priority: trap, then branch, then pending branch, then sequential step.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ce_d          = ce_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    exc_d         = 1'b0;
    addr_d        = addr_q;

    case (state_q)
      PC_IDLE: begin
        state_d = PC_RUN;
        ce_d    = 1'b1;
      end
      PC_RUN, PC_HOLD: begin
        if (trap_valid) begin
          if (trap_mis_c) begin
            exc_d  = 1'b1;
            addr_d = trap_target;
          end else begin
            pc_d         = trap_target;
            pend_valid_d = 1'b0;
            state_d      = PC_RUN;
          end
        end else if (br_valid) begin
          if (br_mis_c) begin
            exc_d  = 1'b1;
            addr_d = br_target;
          end else if (adv_c) begin
            pc_d         = br_target;
            pend_valid_d = 1'b0;
            state_d      = PC_RUN;
          end else begin
            pend_target_d = br_target;
            pend_valid_d  = 1'b1;
            state_d       = PC_HOLD;
          end
        end else if (adv_c) begin
          if (hold_c) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
            state_d      = PC_RUN;
          end else begin
            pc_d = pc_q + step_c;
          end
        end
      end
      default: begin
        state_d = PC_IDLE;
      end
    endcase
  end

  assign pc            = pc_q;
  assign ce            = ce_q;
  assign misalign_exc  = exc_q;
  assign misalign_addr = addr_q;

endmodule : pc_gen
